// File: rtl/seq_barrel_shifter_pkg.sv
// Shared constants for the sequential barrel shifter: op codes, FSM states
// and the default data width.
package seq_barrel_shifter_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [2:0] OP_CLR = 3'b000;
  localparam logic [2:0] OP_LD  = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;
  localparam logic [2:0] OP_ROL = 3'b110;
  localparam logic [2:0] OP_SRI = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/seq_barrel_shifter_if.sv
// Command/result bundle of the sequential barrel shifter.
// master drives commands, slave is the shifter itself.
interface seq_barrel_shifter_if
  import seq_barrel_shifter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  localparam int CNT_W = $clog2(WIDTH);

  logic             start;
  logic [2:0]       op;
  logic [CNT_W-1:0] amt;
  logic [WIDTH-1:0] din;
  logic             sin;
  logic [WIDTH-1:0] dout;
  logic             busy;
  logic             done;

  modport master (
    output start, op, amt, din, sin,
    input  dout, busy, done
  );

  modport slave (
    input  start, op, amt, din, sin,
    output dout, busy, done
  );

endinterface

// File: rtl/seq_barrel_shifter_shift_step.sv
// Combinational single-bit shift/rotate step selected by op.
// CLR/LD never step, so they pass the data through unchanged.
module seq_barrel_shifter_shift_step
  import seq_barrel_shifter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]       op_i,
  input  logic             sin_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] next_data_o
);

  // Select the one-position result for the requested operation.
  always_comb begin
    next_data_o = data_i;
    case (op_i)
      OP_SRL:  next_data_o = {1'b0, data_i[WIDTH-1:1]};
      OP_SLL:  next_data_o = {data_i[WIDTH-2:0], 1'b0};
      OP_SRA:  next_data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
      OP_ROR:  next_data_o = {data_i[0], data_i[WIDTH-1:1]};
      OP_ROL:  next_data_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
      OP_SRI:  next_data_o = {sin_i, data_i[WIDTH-1:1]};
      default: next_data_o = data_i;
    endcase
  end

endmodule

// File: rtl/seq_barrel_shifter.sv
// Registered multi-cycle shifter: one command per start pulse, shifts run
// one bit per clock, with registered busy/done status.
module seq_barrel_shifter
  import seq_barrel_shifter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  seq_barrel_shifter_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_data_s;

  seq_barrel_shifter_shift_step #(.WIDTH(WIDTH)) u_step (
    .op_i        (op_q),
    .sin_i       (bus.sin),
    .data_i      (data_q),
    .next_data_o (step_data_s)
  );

  // Next-state, counter and data update for accept / step / completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          op_d = bus.op;
          case (bus.op)
            OP_CLR: begin
              data_d  = {WIDTH{1'b0}};
              state_d = ST_DONE;
            end
            OP_LD: begin
              data_d  = bus.din;
              state_d = ST_DONE;
            end
            default: begin
              if (bus.amt == {CNT_W{1'b0}}) begin
                state_d = ST_DONE;
              end else begin
                cnt_d   = bus.amt;
                state_d = ST_RUN;
              end
            end
          endcase
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        data_d = step_data_s;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers; reset abandons any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      op_q    <= 3'b000;
      data_q  <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.dout = data_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: doc/seq_barrel_shifter.md
Name: seq_barrel_shifter

Overview:
Registered, multi-cycle shift unit that sits directly downstream of the combinational 4:1 mux selection stage in the 8-bit shifter datapath. It holds an 8-bit data register and executes one command per start pulse: clear, parallel load, or shift/rotate by 0..WIDTH-1 positions. A shift by N runs as N single-bit steps, one step per clock, under a start/busy/done handshake. It feeds the board display and LED logic.

Parameters:
WIDTH, 8, data register width; must be a power of two and at least 2.
CNT_W, $clog2(WIDTH), width of the shift amount and step counter; derived, not overridden.

Ports:
clk  input  1  single system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  command strobe; sampled on the rising clk edge.
op  input  3  command code, captured with start.
amt  input  CNT_W  shift amount, captured with start; ignored for clear and load.
din  input  WIDTH  parallel load data; sampled on the edge that accepts start.
sin  input  1  serial input for SRI; sampled on every step edge, not latched.
dout  output  WIDTH  data register contents.
busy  output  1  high while shift steps are in progress.
done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, active-high): dout=0, busy=0, done=0, step counter=0, latched op=0, state=IDLE. Takes effect immediately, including mid-RUN. The command in progress is abandoned.
- op encoding:
  - 000 CLR: dout=0.
  - 001 LD: dout=din.
  - 010 SRL: logical right, 0 into MSB.
  - 011 SLL: logical left, 0 into LSB.
  - 100 SRA: arithmetic right, MSB replicated.
  - 101 ROR: rotate right, LSB into MSB.
  - 110 ROL: rotate left, MSB into LSB.
  - 111 SRI: right shift, sin into MSB.
- States: IDLE, RUN, DONE. Encoding is internal.
- start is accepted in IDLE or DONE, and is ignored in RUN. Issuing start back-to-back from DONE is legal.
- On an accepting edge k:
  - CLR/LD: dout updates at edge k. State goes to DONE.
  - Shift op with amt=N>0: latch op, counter=N, state goes to RUN, dout unchanged at edge k.
  - Shift op with amt=0: dout unchanged, state goes to DONE. busy never asserts.
- RUN: each edge k+1..k+N applies one single-bit step of the latched op and decrements the counter. At the edge where the counter goes 1->0, state goes to DONE. busy=1 exactly for the N cycles in RUN.
- DONE lasts one cycle. done=1 only in this state. Next state is IDLE, or re-entry via an accepted start.
- Latency summary:
  - CLR/LD/amt=0: done is high in the cycle after the accept edge.
  - Shift by N: done is high N+1 cycles after the accept edge; dout is final from edge k+N.
- busy and done are registered state decodes. They are glitch-free and never both high.
- op, amt, and din changing while in RUN have no effect.
- Counter width is CNT_W. amt of up to WIDTH-1 must never wrap the counter.

Decomposition:
- Shared package: op code constants (OP_CLR..OP_SRI), state encoding constants, and the WIDTH default.
- One sub-module, shift_step: a combinational single-bit shifter with inputs op, sin, data and output next_data. It is instantiated once and selected by op using the existing mux primitives.

Test Plan:
- Reset: hold rst during a RUN with SLL amt=5 on 0xFF -> dout=0x00, busy=0, done=0 asynchronously. After release, stays IDLE until start.
- LD din=0xB5 -> dout=0xB5 after the accept edge; done high exactly one cycle; busy stays 0.
- From 0xB5, SRA amt=3 -> busy high 3 cycles, intermediate values 0xDA, 0xED, 0xF6, final dout=0xF6, then a one-cycle done.
- From 0xB5: ROL amt=4 -> 0x5B; ROR amt=1 -> 0xDA; SLL amt=7 on 0xFF -> 0x80.
- From 0x00, SRI amt=2 with sin=1 -> 0xC0. SRL amt=0 -> dout unchanged, done the next cycle, busy never high.
- start asserted during RUN is ignored and the result is unchanged. start asserted in the DONE cycle (LD 0x3C) is accepted, giving dout=0x3C and a new done pulse one cycle later.
